// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state encoding and retry counter width for the PLL lock controller.
package pll_ctrl_pkg;
    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        READY      = 3'd3,
        FAIL       = 3'd4
    } state_t;
    localparam int RETRY_W   = 2;
    localparam int RETRY_MAX = (1 << RETRY_W) - 1;
endpackage

// File: rtl/sync2.sv
// sync2: generic 2-flop synchronizer, async active-low reset, resets to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= 2'b00;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset/lock sequencer with lock timeout, debounce and bounded retries.
// Optional lock-loss statistics (loss_cnt, lock_loss) under PLL_LOCK_CTRL_LOSS_CNT_EN.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic               refclk,
    input  logic               reset_n,
    input  logic               extlock,
    input  logic               restart,
    output logic               pll_reset,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    ,
    output logic [7:0]         loss_cnt,
    output logic               lock_loss
`endif
);
    localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   ST_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY > RETRY_MAX ? RETRY_MAX : MAX_RETRY);
    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [RETRY_W-1:0] retry_n;
    logic               lock_s;
    sync2 u_sync (.clk(refclk), .rst_n(reset_n), .d(extlock), .q(lock_s));
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        retry_n = retry_cnt;
        case (state)
            RESET_HOLD: if (cnt == RST_LAST) begin
                state_n = WAIT_LOCK;
                cnt_n   = '0;
            end
            WAIT_LOCK: if (lock_s) begin
                state_n = STABLE;
                cnt_n   = '0;
            end else if (cnt == TO_LAST) begin
                cnt_n   = '0;
                state_n = retry_cnt < RETRY_LIM ? RESET_HOLD : FAIL;
                retry_n = retry_cnt < RETRY_LIM ? retry_cnt + 1'b1 : retry_cnt;
            end
            STABLE: if (!lock_s) begin
                state_n = WAIT_LOCK;
                cnt_n   = '0;
            end else if (cnt == ST_LAST) begin
                state_n = READY;
                cnt_n   = '0;
            end
            READY: begin
                cnt_n   = '0;
                state_n = lock_s ? READY : RESET_HOLD;
            end
            FAIL: cnt_n = '0;
            default: begin
                state_n = RESET_HOLD;
                cnt_n   = '0;
            end
        endcase
        if (restart) begin
            state_n = RESET_HOLD;
            cnt_n   = '0;
            retry_n = '0;
        end
    end
    // Outputs are registered from state_n so the PLL reset pin never sees decode glitches.
    always_ff @(posedge refclk or negedge reset_n)
        if (!reset_n) begin
            state     <= RESET_HOLD;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            retry_cnt <= retry_n;
            pll_reset <= state_n == RESET_HOLD || state_n == FAIL;
            ready     <= state_n == READY;
            fail      <= state_n == FAIL;
        end
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    logic loss;
    assign loss = state == READY && !lock_s && !restart;
    always_ff @(posedge refclk or negedge reset_n)
        if (!reset_n) begin
            loss_cnt  <= '0;
            lock_loss <= 1'b0;
        end else begin
            lock_loss <= loss;
            loss_cnt  <= loss && loss_cnt != 8'hFF ? loss_cnt + 1'b1 : loss_cnt;
        end
`endif
endmodule
